// File: rtl/i2c_lm75a_target.sv
// LM75A-compatible I2C target: oversamples scl/sda on clk and drives sda open-drain only.
// Optional macro I2C_LM75A_OS_EN adds the overtemperature comparator and the os port.
module i2c_lm75a_target #(
  parameter logic [6:0] DEV_ADDR = 7'h48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] temp_data,
  output logic        busy,
  output logic [1:0]  ptr_tb
`ifdef I2C_LM75A_OS_EN
  ,
  output logic        os
`endif
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT
  } state_t;

  state_t      state, state_n;
  logic [2:0]  scl_q, sda_q;
  logic        scl_rise, scl_fall, sda_s, start_det, stop_det;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [6:0]  rx_sh, rx_sh_n;
  logic [7:0]  rx_byte, rd_byte, tx_sh, tx_sh_n;
  logic        sda_oe, sda_oe_n, busy_n, rw, rw_n, first, first_n, rd_lsb, rd_lsb_n;
  logic [1:0]  ptr, ptr_n, wr_idx, wr_idx_n;
  logic [7:0]  cfg, cfg_n;
  logic [15:0] thyst, thyst_n, tos, tos_n, shadow, shadow_n;

  assign sda    = sda_oe ? 1'b0 : 1'bz;
  assign ptr_tb = ptr;

  // Two-flop synchronizers plus a third stage for edge detection; reset to idle bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign rx_byte   = {rx_sh, sda_s};
  assign rd_byte   = (ptr == 2'd1) ? cfg : (rd_lsb ? shadow[7:0] : shadow[15:8]);

  always_comb begin
    state_n  = state;
    bit_cnt_n = bit_cnt;
    rx_sh_n  = rx_sh;
    tx_sh_n  = tx_sh;
    sda_oe_n = sda_oe;
    busy_n   = busy;
    rw_n     = rw;
    first_n  = first;
    rd_lsb_n = rd_lsb;
    ptr_n    = ptr;
    wr_idx_n = wr_idx;
    cfg_n    = cfg;
    thyst_n  = thyst;
    tos_n    = tos;
    shadow_n = shadow;
    case (state)
      IDLE, WAIT: sda_oe_n = 1'b0;
      ADDR: if (scl_rise) begin
        rx_sh_n   = rx_byte[6:0];
        bit_cnt_n = bit_cnt + 4'd1;
        if (bit_cnt == 4'd7) begin
          bit_cnt_n = 4'd0;
          if (rx_byte[7:1] == DEV_ADDR) begin
            state_n  = ADDR_ACK;
            busy_n   = 1'b1;
            rw_n     = rx_byte[0];
            first_n  = 1'b1;
            wr_idx_n = 2'd0;
            rd_lsb_n = 1'b0;
            if (rx_byte[0]) begin
              case (ptr)
                2'd0:    shadow_n = temp_data;
                2'd2:    shadow_n = thyst;
                2'd3:    shadow_n = tos;
                default: shadow_n = {cfg, cfg};
              endcase
            end
          end else begin
            state_n = WAIT;
          end
        end
      end
      // First scl fall asserts ACK, second fall ends the ACK slot.
      ADDR_ACK, WR_ACK: if (scl_fall) begin
        if (!sda_oe) begin
          sda_oe_n = 1'b1;
        end else if (state == ADDR_ACK && rw) begin
          state_n   = RD_BYTE;
          sda_oe_n  = ~rd_byte[7];
          tx_sh_n   = {rd_byte[6:0], 1'b0};
          bit_cnt_n = 4'd1;
        end else begin
          state_n   = WR_BYTE;
          sda_oe_n  = 1'b0;
          bit_cnt_n = 4'd0;
        end
      end
      WR_BYTE: if (scl_rise) begin
        rx_sh_n   = rx_byte[6:0];
        bit_cnt_n = bit_cnt + 4'd1;
        if (bit_cnt == 4'd7) begin
          bit_cnt_n = 4'd0;
          state_n   = WR_ACK;
          if (first) begin
            ptr_n   = rx_byte[1:0];
            first_n = 1'b0;
          end else begin
            if (wr_idx != 2'd3) wr_idx_n = wr_idx + 2'd1;
            case (ptr)
              2'd1: if (wr_idx == 2'd0) cfg_n = rx_byte;
              2'd2: begin
                if (wr_idx == 2'd0) thyst_n[15:8] = rx_byte;
                else if (wr_idx == 2'd1) thyst_n[7:0] = rx_byte;
              end
              2'd3: begin
                if (wr_idx == 2'd0) tos_n[15:8] = rx_byte;
                else if (wr_idx == 2'd1) tos_n[7:0] = rx_byte;
              end
              default: ;
            endcase
          end
        end
      end
      RD_BYTE: if (scl_fall) begin
        if (bit_cnt == 4'd8) begin
          state_n  = RD_ACK;
          sda_oe_n = 1'b0;
          rd_lsb_n = ~rd_lsb;
        end else begin
          sda_oe_n  = ~tx_sh[7];
          tx_sh_n   = {tx_sh[6:0], 1'b0};
          bit_cnt_n = bit_cnt + 4'd1;
        end
      end
      RD_ACK: begin
        sda_oe_n = 1'b0;
        if (scl_rise) begin
          if (!sda_s) begin
            state_n   = RD_BYTE;
            tx_sh_n   = rd_byte;
            bit_cnt_n = 4'd0;
          end else begin
            state_n = WAIT;
            busy_n  = 1'b0;
          end
        end
      end
    endcase
    // START/STOP abort whatever is in flight; partial bytes are dropped.
    if (start_det || stop_det) begin
      state_n   = start_det ? ADDR : IDLE;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rx_sh   <= '0;
      tx_sh   <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      rw      <= 1'b0;
      first   <= 1'b0;
      rd_lsb  <= 1'b0;
      ptr     <= 2'd0;
      wr_idx  <= 2'd0;
      cfg     <= 8'h00;
      thyst   <= 16'h4B00;
      tos     <= 16'h5000;
      shadow  <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      rx_sh   <= rx_sh_n;
      tx_sh   <= tx_sh_n;
      sda_oe  <= sda_oe_n;
      busy    <= busy_n;
      rw      <= rw_n;
      first   <= first_n;
      rd_lsb  <= rd_lsb_n;
      ptr     <= ptr_n;
      wr_idx  <= wr_idx_n;
      cfg     <= cfg_n;
      thyst   <= thyst_n;
      tos     <= tos_n;
      shadow  <= shadow_n;
    end
  end

`ifdef I2C_LM75A_OS_EN
  // Comparator with hysteresis on the 9-bit signed integer/half-degree field.
  logic os_act, os_act_n;

  always_comb begin
    os_act_n = os_act;
    if ($signed(temp_data[15:7]) > $signed(tos[15:7])) os_act_n = 1'b1;
    else if ($signed(temp_data[15:7]) < $signed(thyst[15:7])) os_act_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      os_act <= 1'b0;
      os     <= 1'b0;
    end else begin
      os_act <= os_act_n;
      os     <= os_act_n ^ cfg[2];
    end
  end
`endif

endmodule

// File: tb/tb_i2c_lm75a_target.sv
// Bench for i2c_lm75a_target: bit-banged I2C master plus a transaction-level LM75A model.
module tb_i2c_lm75a_target;

  localparam int unsigned HALF = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        scl_m;
  logic        mst_sda;
  logic [15:0] temp_data;
  logic        busy;
  logic [1:0]  ptr_tb;
`ifdef I2C_LM75A_OS_EN
  logic        os;
`endif
  wire         sda;

  pullup (sda);
  assign sda = mst_sda ? 1'bz : 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic       cmp_valid = 1'b0;
  logic       exp_bus   = 1'b1;
  logic       exp_busy  = 1'b0;
  logic [1:0] exp_ptr   = 2'd0;

  // Transaction-level model of the target's register file
  logic [15:0] m_reg [4];
  logic [7:0]  m_cfg;
  logic [1:0]  m_ptr;
  logic        m_first, m_ack, m_half;
  int          m_widx;
  logic [15:0] m_word;

  always #5 clk = ~clk;

  i2c_lm75a_target dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl_m),
    .sda       (sda),
    .temp_data (temp_data),
    .busy      (busy),
    .ptr_tb    (ptr_tb)
`ifdef I2C_LM75A_OS_EN
    ,
    .os        (os)
`endif
  );

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Continuous compare while scl is high and the bus is settled
  always @(negedge clk) begin
    if (cmp_valid) begin
      check("bus_sda", 16'(sda), 16'(exp_bus));
      check("busy", 16'(busy), 16'(exp_busy));
      check("ptr_tb", 16'(ptr_tb), 16'(exp_ptr));
    end
  end

  task automatic model_reset();
    m_reg[0] = 16'h0000;
    m_reg[1] = 16'h0000;
    m_reg[2] = 16'h4B00;
    m_reg[3] = 16'h5000;
    m_cfg    = 8'h00;
    m_ptr    = 2'd0;
    m_first  = 1'b0;
    m_widx   = 0;
    m_half   = 1'b0;
    m_word   = 16'h0000;
    exp_ptr  = 2'd0;
    exp_busy = 1'b0;
  endtask

  task automatic model_byte_written(input logic [7:0] b, input logic is_addr);
    if (is_addr) begin
      m_ack = (b[7:1] == 7'h48);
      if (m_ack) begin
        exp_busy = 1'b1;
        m_first  = 1'b1;
        m_widx   = 0;
        m_half   = 1'b0;
        m_word   = (m_ptr == 2'd0) ? temp_data : m_reg[m_ptr];
      end
    end else begin
      m_ack = 1'b1;
      if (m_first) begin
        m_ptr   = b[1:0];
        m_first = 1'b0;
      end else begin
        if (m_ptr == 2'd1 && m_widx == 0) m_cfg = b;
        if (m_ptr >= 2'd2 && m_widx == 0) m_reg[m_ptr][15:8] = b;
        if (m_ptr >= 2'd2 && m_widx == 1) m_reg[m_ptr][7:0] = b;
        m_widx++;
      end
      exp_ptr = m_ptr;
    end
  endtask

  function automatic logic [7:0] model_read_byte();
    logic [7:0] r;
    if (m_ptr == 2'd1) r = m_cfg;
    else r = m_half ? m_word[7:0] : m_word[15:8];
    m_half = ~m_half;
    return r;
  endfunction

  // One scl period; drv=1 releases sda. Returns the bus value seen mid-high.
  task automatic clock_bit(input logic drv, input logic exp, output logic got);
    mst_sda = drv;
    wait_clk(HALF);
    scl_m = 1'b1;
    wait_clk(5);
    exp_bus   = exp;
    cmp_valid = 1'b1;
    got       = sda;
    wait_clk(HALF - 5);
    cmp_valid = 1'b0;
    scl_m     = 1'b0;
    wait_clk(3);
  endtask

  task automatic i2c_start();
    mst_sda = 1'b1;
    wait_clk(3);
    scl_m = 1'b1;
    wait_clk(HALF);
    mst_sda  = 1'b0;
    exp_busy = 1'b0;
    wait_clk(HALF);
    scl_m = 1'b0;
    wait_clk(3);
  endtask

  task automatic i2c_stop();
    mst_sda = 1'b0;
    wait_clk(3);
    scl_m = 1'b1;
    wait_clk(HALF);
    mst_sda  = 1'b1;
    exp_busy = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic is_addr, output logic acked);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) model_byte_written(b, is_addr);
      clock_bit(b[i], b[i], g);
    end
    clock_bit(1'b1, ~m_ack, g);
    acked = ~g;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] got);
    logic [7:0] mb;
    logic g;
    mb = model_read_byte();
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, mb[i], g);
      got[i] = g;
    end
    if (nack) exp_busy = 1'b0;
    clock_bit(nack, nack, g);
  endtask

  initial begin
    logic       ack;
    logic [7:0] b;
    reset     = 1'b1;
    scl_m     = 1'b1;
    mst_sda   = 1'b1;
    temp_data = 16'h1960;
    model_reset();
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);
    check("rst_bus", 16'(sda), 16'h1);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_ptr", 16'(ptr_tb), 16'h0);
`ifdef I2C_LM75A_OS_EN
    check("rst_os", 16'(os), 16'h0);
`endif

    // Temperature read; temp_data changes mid-transfer must not tear
    i2c_start();
    write_byte(8'h91, 1'b1, ack);
    check("t1_addr_ack", 16'(ack), 16'h1);
    read_byte(1'b0, b);
    check("t1_msb", 16'(b), 16'h0019);
    temp_data = 16'hFFFF;
    read_byte(1'b1, b);
    check("t1_lsb", 16'(b), 16'h0060);
    check("t1_busy_nack", 16'(busy), 16'h0);
    i2c_stop();
    temp_data = 16'h1960;

    // Foreign address: no ACK
    i2c_start();
    write_byte(8'h95, 1'b1, ack);
    check("t2_no_ack", 16'(ack), 16'h0);
    i2c_stop();
    check("t2_busy", 16'(busy), 16'h0);

    // Write Tos then read it back
    i2c_start();
    write_byte(8'h90, 1'b1, ack);
    write_byte(8'h03, 1'b0, ack);
    write_byte(8'h55, 1'b0, ack);
    write_byte(8'h00, 1'b0, ack);
    i2c_start();
    write_byte(8'h91, 1'b1, ack);
    read_byte(1'b0, b);
    check("t3_msb", 16'(b), 16'h0055);
    read_byte(1'b1, b);
    check("t3_lsb", 16'(b), 16'h0000);
    check("t3_ptr", 16'(ptr_tb), 16'h3);
    i2c_stop();

    // Config pointer via repeated START: single byte repeats
    i2c_start();
    write_byte(8'h90, 1'b1, ack);
    write_byte(8'h01, 1'b0, ack);
    i2c_start();
    write_byte(8'h91, 1'b1, ack);
    for (int k = 0; k < 3; k++) begin
      read_byte(k == 2, b);
      check("t4_cfg", 16'(b), 16'h0000);
    end
    check("t4_ptr", 16'(ptr_tb), 16'h1);
    i2c_stop();

    // Reset while the target is driving a 0 data bit
    i2c_start();
    write_byte(8'h90, 1'b1, ack);
    write_byte(8'h00, 1'b0, ack);
    i2c_start();
    write_byte(8'h91, 1'b1, ack);
    wait_clk(3);
    check("t5_driving", 16'(sda), 16'h0);
    reset = 1'b1;
    wait_clk(1);
    check("t5_released", 16'(sda), 16'h1);
    check("t5_busy", 16'(busy), 16'h0);
    check("t5_ptr", 16'(ptr_tb), 16'h0);
    reset = 1'b0;
    model_reset();
    wait_clk(2);
    i2c_start();
    write_byte(8'h90, 1'b1, ack);
    write_byte(8'h03, 1'b0, ack);
    i2c_start();
    write_byte(8'h91, 1'b1, ack);
    read_byte(1'b0, b);
    check("t5_tos_msb", 16'(b), 16'h0050);
    read_byte(1'b1, b);
    check("t5_tos_lsb", 16'(b), 16'h0000);
    i2c_stop();

`ifdef I2C_LM75A_OS_EN
    check("os_idle", 16'(os), 16'h0);
    temp_data = 16'h5080;
    wait_clk(5);
    check("os_set", 16'(os), 16'h1);
    temp_data = 16'h4C00;
    wait_clk(5);
    check("os_hold", 16'(os), 16'h1);
    temp_data = 16'h4A80;
    wait_clk(5);
    check("os_clear", 16'(os), 16'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_lm75a_target.md
# i2c_lm75a_target

I2C target (slave) that emulates an LM75A temperature sensor on the shared `scl`/`sda` bus. It is the bus-side counterpart of the I2C master that polls the LM75A: it lets the master be exercised on-chip and in simulation without the physical part, and can present any 16-bit temperature value supplied by other logic. It is fully synchronous to the system clock and oversamples `scl`/`sda`; it never drives `scl`.

## Interface
- `DEV_ADDR`, 7'h48: 7-bit target address (LM75A, A2..A0 = 0).
- `clk`  input  1  system clock; the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `scl`  input  1  I2C clock from master.
- `sda`  inout  1  I2C data; open-drain: driven `0` or `z`, never `1`.
- `temp_data`  input  16  temperature register contents (LM75A format, bits 4:0 as supplied).
- `busy`  output  1  high from address match until STOP/START/NACK.
- `ptr_tb`  output  2  current pointer register, for benches.
- `os`  output  1  overtemperature output (only with `I2C_LM75A_OS_EN`).

## Operation
- `scl`, `sda` pass through 2-FF synchronizers; edges detected from 3rd stage vs 2nd.
- START = sda fall while scl high; STOP = sda rise while scl high. Both override any state.
- Registers: ptr[1:0]=0, config[7:0]=8'h00, thyst[15:0]=16'h4B00, tos[15:0]=16'h5000 at reset. Pointer 0 reads `temp_data` (writes ignored, ACKed).
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT.
  - IDLE: sda released; START -> ADDR.
  - ADDR: shift 8 bits MSB-first on scl rise. Match of bits 7:1 to `DEV_ADDR` -> ADDR_ACK; else WAIT (no ACK).
  - ADDR_ACK: pull sda low for one scl low-high-low period. R/W=1: capture read shadow (`temp_data` if ptr=0), -> RD_BYTE; R/W=0 -> WR_BYTE.
  - WR_BYTE: shift 8 bits; first byte after address loads ptr from bits 1:0 (7:2 ignored); later bytes load selected register MSB then LSB (config: single byte). Bytes beyond register width ignored. -> WR_ACK (always ACK) -> WR_BYTE.
  - RD_BYTE: present MSB-first; config returns same byte each read; 16-bit registers alternate MSB, LSB, MSB... -> RD_ACK.
  - RD_ACK: sda released; sample master bit on scl rise: 0 -> RD_BYTE, 1 (NACK) -> WAIT.
  - WAIT: sda released until START (-> ADDR) or STOP (-> IDLE).
- Repeated START in any state: abort current byte, -> ADDR; ptr retained.
- Partial byte at STOP/START is discarded; register not updated.

## Timing
- Input sync latency 2 cycles; edge flags valid 3 cycles after pin change.
- sda output changes 1 cycle after detected scl falling edge (data/ACK set-up); released 1 cycle after the falling edge ending ACK/bit.
- Bits sampled on the cycle the scl rising edge is detected.
- Minimum supported scl high/low time: 8 `clk` cycles.
- Read shadow captured once per read transfer; `temp_data` changes mid-transfer do not tear the 16-bit value.
- `busy` rises in the cycle ADDR_ACK is entered; falls the cycle STOP, START or NACK is detected.
- Reset: all states above, sda released (`z`) the cycle after `reset` sampled high, regardless of bus activity; `busy`=0, `ptr_tb`=0, `os`=0.

## Configuration
- `I2C_LM75A_OS_EN` defined: `os` port present; comparator mode, registered: set when signed `temp_data[15:7]` > `tos[15:7]`, cleared when < `thyst[15:7]`, otherwise held; config[2] inverts polarity (reset value drives `0` as inactive). Evaluated every cycle.
- Not defined: `os` port and comparator logic absent; config byte still stored and readable.

## Test plan
- `temp_data`=16'h1960, master reads 0x91 then 2 bytes -> ACK on address, bytes 0x19, 0x60, master NACK -> WAIT, `busy` falls.
- Master addresses 0x4A (8'h95) -> no ACK, sda never driven low by target through STOP.
- Write 8'h90, 8'h03, 8'h55, 8'h00; START, 8'h91, read 2 -> returns 0x55, 0x00; `ptr_tb`=3.
- Write 8'h90, 8'h01, then repeated START, 8'h91, read 3 bytes ACKed -> 0x00, 0x00, 0x00 (config repeats).
- Assert `reset` during RD_BYTE while driving 0 -> sda `z` next cycle, tos=16'h5000, ptr=0.
- With `I2C_LM75A_OS_EN`: `temp_data` 16'h5080 -> `os`=1; 16'h4C00 -> stays 1; 16'h4A80 -> `os`=0.
